// File: rtl/apb_gpio_pkg.sv
// Shared register map, reset values and capability-field layout for the APB GPIO port.
package apb_gpio_pkg;

   // Word indices decoded from paddr[7:2]
   localparam logic [5:0] REG_DATA   = 6'd0;
   localparam logic [5:0] REG_OUT    = 6'd1;
   localparam logic [5:0] REG_DIR    = 6'd2;
   localparam logic [5:0] REG_IMASK  = 6'd3;
   localparam logic [5:0] REG_IPOL   = 6'd4;
   localparam logic [5:0] REG_IEDGE  = 6'd5;
   localparam logic [5:0] REG_BYPASS = 6'd6;
   localparam logic [5:0] REG_CAP    = 6'd7;

   // Reset values for control registers and the input synchroniser chain
   localparam logic [31:0] RST_REG  = 32'h0000_0000;
   localparam logic [31:0] RST_SYNC = 32'h0000_0000;

   // CAP register layout: implemented-bit count minus one, and interrupt capability flag
   localparam int CAP_NB_LSB  = 0;
   localparam int CAP_NB_W    = 5;
   localparam int CAP_IRQ_BIT = 16;

   // Mask with the low n bits set (n clamped to 0..32)
   function automatic logic [31:0] bit_mask(input int n);
      if (n >= 32) begin
         return 32'hFFFF_FFFF;
      end else if (n <= 0) begin
         return 32'h0000_0000;
      end else begin
         return (32'd1 << n) - 32'd1;
      end
   endfunction

endpackage

// File: rtl/apb_gpio_port_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, one chain per bit.
module gpio_sync2
   import apb_gpio_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] s1_q;
   logic [W-1:0] s2_q;

   // Metastability chain: first flop samples the pad, second presents the settled value
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= RST_SYNC[W-1:0];
         s2_q <= RST_SYNC[W-1:0];
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/apb_gpio_port.sv
// APB-attached GPIO controller: per-bit output data, direction, alternate-function
// bypass and level/edge input interrupts, with a two-flop input synchroniser.
module apb_gpio_port
   import apb_gpio_pkg::*;
#(
   parameter int          NBITS  = 8,
   parameter bit          OEPOL  = 1'b0,
   parameter logic [31:0] IMASK  = 32'h0,
   parameter logic [31:0] BYPASS = 32'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        psel,
   input  logic        penable,
   input  logic [31:0] paddr,
   input  logic        pwrite,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pirq,
   input  logic [31:0] gpio_din,
   input  logic [31:0] sig_in,
   input  logic [31:0] sig_en,
   output logic [31:0] gpio_dout,
   output logic [31:0] gpio_oen,
   output logic [31:0] gpio_val,
   output logic [31:0] sig_out
);

   // Bits that exist at all, bits that may interrupt, bits that may be bypassed
   localparam logic [31:0] IMP_MASK = bit_mask(NBITS);
   localparam logic [31:0] IRQ_MASK = IMP_MASK & IMASK;
   localparam logic [31:0] BYP_MASK = IMP_MASK & BYPASS;

   logic [31:0] out_q,   out_d;
   logic [31:0] dir_q,   dir_d;
   logic [31:0] imask_q, imask_d;
   logic [31:0] ipol_q,  ipol_d;
   logic [31:0] iedge_q, iedge_d;
   logic [31:0] byp_q,   byp_d;
   logic [31:0] prev_q;

   logic [31:0] sync_raw;
   logic [31:0] sync;
   logic [31:0] byp_wmask;
   logic [31:0] evt;
   logic [31:0] cap;
   logic [5:0]  widx;
   logic        wr_en;
   logic        unused_addr;

   assign widx        = paddr[7:2];
   assign wr_en       = psel & penable & pwrite;
   assign unused_addr = ^{paddr[31:8], paddr[1:0]};

   // A bypass bit can only be set where the build allows it and an alternate function exists
   assign byp_wmask = BYP_MASK & sig_en;

   gpio_sync2 #(.W(32)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d_i  (gpio_din),
      .q_o  (sync_raw)
   );

   assign sync = sync_raw & IMP_MASK;

   // Register next-state: apply an APB write, keeping unimplemented bits at zero
   always_comb begin
      out_d   = out_q;
      dir_d   = dir_q;
      imask_d = imask_q;
      ipol_d  = ipol_q;
      iedge_d = iedge_q;
      byp_d   = byp_q;
      if (wr_en) begin
         case (widx)
            REG_OUT:    out_d   = pwdata & IMP_MASK;
            REG_DIR:    dir_d   = pwdata & IMP_MASK;
            REG_IMASK:  imask_d = pwdata & IRQ_MASK;
            REG_IPOL:   ipol_d  = pwdata & IRQ_MASK;
            REG_IEDGE:  iedge_d = pwdata & IRQ_MASK;
            REG_BYPASS: byp_d   = (byp_q & ~byp_wmask) | (pwdata & byp_wmask);
            default:    ;
         endcase
      end
   end

   // Control registers and previous-input flop for edge detection
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q   <= RST_REG;
         dir_q   <= RST_REG;
         imask_q <= RST_REG;
         ipol_q  <= RST_REG;
         iedge_q <= RST_REG;
         byp_q   <= RST_REG;
         prev_q  <= RST_SYNC;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         imask_q <= imask_d;
         ipol_q  <= ipol_d;
         iedge_q <= iedge_d;
         byp_q   <= byp_d;
         prev_q  <= sync;
      end
   end

   // Per-bit event: polarity match, additionally qualified by a change when in edge mode
   assign evt  = ~(sync ^ ipol_q) & (~iedge_q | (sync ^ prev_q));
   assign pirq = |(imask_q & evt);

   // Capability word is fixed by the build parameters
   always_comb begin
      cap                              = '0;
      cap[CAP_NB_LSB +: CAP_NB_W]      = CAP_NB_W'(NBITS - 1);
      cap[CAP_IRQ_BIT]                 = (IMASK != 32'h0);
   end

   // Read mux, only driven while the slave is selected
   always_comb begin
      prdata = '0;
      if (psel) begin
         case (widx)
            REG_DATA:   prdata = sync;
            REG_OUT:    prdata = out_q;
            REG_DIR:    prdata = dir_q;
            REG_IMASK:  prdata = imask_q;
            REG_IPOL:   prdata = ipol_q;
            REG_IEDGE:  prdata = iedge_q;
            REG_BYPASS: prdata = byp_q;
            REG_CAP:    prdata = cap;
            default:    prdata = '0;
         endcase
      end
   end

   assign gpio_dout = (byp_q & sig_in) | (~byp_q & out_q);
   assign gpio_oen  = OEPOL ? dir_q : ~dir_q;
   assign gpio_val  = sync;
   assign sig_out   = sync;

endmodule

// File: tb/tb_apb_gpio_port.sv
// Randomised bench for apb_gpio_port with a per-bit behavioural model and directed pins.
module tb_apb_gpio_port;

   localparam int          NB  = 8;
   localparam logic [31:0] IMP = 32'h0000_00FF;
   localparam logic [31:0] BYP = 32'h0000_000F;

   logic        clk = 1'b0;
   logic        rstn;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] gpio_din, sig_in, sig_en;
   logic [31:0] prdata, gpio_dout, gpio_oen, gpio_val, sig_out;
   logic        pirq;
   logic [31:0] oen_p;
   logic [31:0] unused_prdata_p, unused_dout_p, unused_val_p, unused_sigout_p;
   logic        unused_pirq_p;

   int tests = 0;
   int fails = 0;
   bit run_chk = 1'b0;

   always #5 clk = ~clk;

   apb_gpio_port #(.NBITS(NB), .OEPOL(1'b0), .IMASK(IMP), .BYPASS(BYP)) dut (
      .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pirq(pirq),
      .gpio_din(gpio_din), .sig_in(sig_in), .sig_en(sig_en), .gpio_dout(gpio_dout),
      .gpio_oen(gpio_oen), .gpio_val(gpio_val), .sig_out(sig_out)
   );

   apb_gpio_port #(.NBITS(NB), .OEPOL(1'b1), .IMASK(IMP), .BYPASS(BYP)) dut_p (
      .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .paddr(paddr),
      .pwrite(pwrite), .pwdata(pwdata), .prdata(unused_prdata_p), .pirq(unused_pirq_p),
      .gpio_din(gpio_din), .sig_in(sig_in), .sig_en(sig_en), .gpio_dout(unused_dout_p),
      .gpio_oen(oen_p), .gpio_val(unused_val_p), .sig_out(unused_sigout_p)
   );

   // ---------------- behavioural model ----------------
   logic [31:0] m_out, m_dir, m_imask, m_ipol, m_iedge, m_byp;
   logic [31:0] hist [0:2];   // pad values captured at the last three edges, [0] newest

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_sync();
      return hist[1];
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (a[7:2])
         6'd0: return m_sync();
         6'd1: return m_out;
         6'd2: return m_dir;
         6'd3: return m_imask;
         6'd4: return m_ipol;
         6'd5: return m_iedge;
         6'd6: return m_byp;
         6'd7: return (NB - 1) | ((IMP != 0) ? 32'h0001_0000 : 32'h0);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic m_irq();
      logic [31:0] s, p;
      logic any;
      s = hist[1];
      p = hist[2];
      any = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (m_imask[i]) begin
            if (m_iedge[i]) begin
               if (s[i] != p[i] && s[i] == m_ipol[i]) any = 1'b1;
            end else begin
               if (s[i] == m_ipol[i]) any = 1'b1;
            end
         end
      end
      return any;
   endfunction

   function automatic logic [31:0] m_dout();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NB; i++) r[i] = m_byp[i] ? sig_in[i] : m_out[i];
      return r;
   endfunction

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [31:0] en);
      case (a[7:2])
         6'd1: m_out   = d & IMP;
         6'd2: m_dir   = d & IMP;
         6'd3: m_imask = d & IMP & IMP;
         6'd4: m_ipol  = d & IMP;
         6'd5: m_iedge = d & IMP;
         6'd6: for (int i = 0; i < NB; i++) if (BYP[i] && en[i]) m_byp[i] = d[i];
         default: ;
      endcase
   endtask

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_out = 0; m_dir = 0; m_imask = 0; m_ipol = 0; m_iedge = 0; m_byp = 0;
         hist[0] = 0; hist[1] = 0; hist[2] = 0;
      end else begin
         if (psel && penable && pwrite) m_write(paddr, pwdata, sig_en);
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = gpio_din & IMP;
      end
   end

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (run_chk) begin
         check("dout", gpio_dout, m_dout());
         check("oen", gpio_oen, ~m_dir);
         check("oen_pol1", oen_p, m_dir);
         check("val", gpio_val, m_sync());
         check("sig_out", sig_out, m_sync());
         check("pirq", {31'b0, pirq}, {31'b0, m_irq()});
         if (psel) check("prdata", prdata, m_read(paddr));
         else      check("prdata_idle", prdata, 32'h0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
      tick();
      penable = 1;
      tick();
      psel = 0; penable = 0; pwrite = 0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
      psel = 1; penable = 0; pwrite = 0; paddr = a;
      tick();
      penable = 1;
      @(negedge clk);
      d = prdata;
      tick();
      psel = 0; penable = 0;
   endtask

   logic [31:0] rd;
   int pcnt, ppos;

   initial begin
      rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      gpio_din = 0; sig_in = 0; sig_en = 0;
      run_chk = 1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_oen", gpio_oen, 32'hFFFF_FFFF);
      check("rst_dout", gpio_dout, 32'h0);
      check("rst_pirq", {31'b0, pirq}, 32'h0);
      tick();
      rstn = 1;
      tick();

      apb_read(32'h1C, rd); check("cap", rd, 32'h0001_0007);
      apb_read(32'h04, rd); check("rst_out", rd, 32'h0);
      apb_read(32'h08, rd); check("rst_dir", rd, 32'h0);

      gpio_din = 32'h1;
      apb_write(32'h04, 32'h0BAD_F00D);
      @(negedge clk); check("out_dout", gpio_dout, 32'h0000_000D);
      apb_read(32'h04, rd); check("out_rd", rd, 32'h0000_000D);

      apb_write(32'h100, 32'h0002_0000);
      apb_read(32'h200, rd); check("alias_data", rd, 32'h0000_0001);
      apb_write(32'h300, 32'hFFFF_FFFF);
      apb_read(32'h04, rd); check("alias_noeff", rd, 32'h0000_000D);

      apb_write(32'h08, 32'h0F);
      @(negedge clk);
      check("dir_oen", gpio_oen, 32'hFFFF_FFF0);
      check("dir_oen_pol1", oen_p, 32'h0000_000F);

      // edge interrupt on bit 0
      gpio_din = 32'h0;
      repeat (4) tick();
      apb_write(32'h14, 32'h1);
      apb_write(32'h10, 32'h1);
      apb_write(32'h0C, 32'h1);
      repeat (2) tick();
      @(negedge clk); check("edge_idle", {31'b0, pirq}, 32'h0);
      tick();
      gpio_din = 32'h1;
      pcnt = 0; ppos = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (pirq) begin
            pcnt++;
            if (ppos < 0) ppos = k;
         end
      end
      check("edge_cnt", pcnt, 1);
      check("edge_pos", ppos, 2);

      // level mode holds while the pad stays high
      tick();
      apb_write(32'h14, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); check("level_hold", {31'b0, pirq}, 32'h1);
      end
      tick();
      gpio_din = 32'h0;
      repeat (3) tick();
      @(negedge clk); check("level_drop", {31'b0, pirq}, 32'h0);
      tick();

      // alternate-function bypass
      sig_en = 32'h2; sig_in = 32'h2;
      apb_write(32'h04, 32'h0);
      apb_write(32'h18, 32'h2);
      @(negedge clk); check("byp_dout", gpio_dout, 32'h0000_0002);
      tick();
      apb_write(32'h18, 32'h0);
      sig_en = 32'h0;
      apb_write(32'h18, 32'h2);
      apb_read(32'h18, rd); check("byp_blocked", rd, 32'h0);

      // reset during an access phase leaves no partial write
      psel = 1; pwrite = 1; paddr = 32'h08; pwdata = 32'hFF; penable = 0;
      tick();
      penable = 1;
      rstn = 0;
      tick();
      psel = 0; penable = 0; pwrite = 0;
      tick();
      rstn = 1;
      tick();
      apb_read(32'h08, rd); check("rst_abort", rd, 32'h0);

      // randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) gpio_din = $urandom;
         sig_in = $urandom;
         if ($urandom_range(7) == 0) sig_en = $urandom;
         psel    = ($urandom_range(3) != 0);
         penable = $urandom_range(1);
         pwrite  = $urandom_range(1);
         paddr   = {$urandom_range(255)};
         paddr[1:0] = 2'($urandom_range(3));
         paddr[7:2] = ($urandom_range(3) != 0) ? 6'($urandom_range(7)) : 6'($urandom_range(63));
         paddr[31:8] = ($urandom_range(3) == 0) ? 24'($urandom) : 24'h0;
         pwdata  = $urandom;
         tick();
      end
      psel = 0; penable = 0; pwrite = 0;
      tick();
      @(negedge clk);
      run_chk = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
